// File: rtl/pool_fmap_pingpong.sv
// Ping-pong capture buffer for pooled feature maps: two banks filled from a
// valid-only pixel stream, replayed in raster order over valid/ready.
module pool_fmap_pingpong #(
    parameter int MAP_DIM = 14,
    parameter int DATA_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_pixel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_pixel,
    output logic                     out_last,
    output logic                     frame_done,
    output logic [1:0]               bank_full,
    output logic                     overflow
);
    localparam int DEPTH  = MAP_DIM * MAP_DIM;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {RD_IDLE, RD_LOAD, RD_STREAM} rd_state_t;

    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];

    rd_state_t         state, state_n;
    logic              wr_bank, rd_bank;
    logic [ADDR_W-1:0] wr_addr, rd_addr, rd_addr_n, rd_idx;
    logic              wr_en, wr_last, fire;
    logic              pix_ld, valid_n, done_n, rd_free;
    logic [1:0]        bank_full_n;

    assign wr_en   = in_valid && !bank_full[wr_bank];
    assign wr_last = wr_en && (wr_addr == LAST_ADDR);
    assign fire    = out_valid && out_ready;
    assign out_last = out_valid && (rd_addr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_bank)
                mem1[wr_addr] <= in_pixel;
            else
                mem0[wr_addr] <= in_pixel;
        end
    end

    always_comb begin
        state_n   = state;
        rd_addr_n = rd_addr;
        rd_idx    = '0;
        pix_ld    = 1'b0;
        valid_n   = out_valid;
        done_n    = 1'b0;
        rd_free   = 1'b0;
        case (state)
            RD_IDLE: begin
                if (bank_full[rd_bank]) begin
                    rd_addr_n = '0;
                    state_n   = RD_LOAD;
                end
            end
            RD_LOAD: begin
                pix_ld  = 1'b1;
                valid_n = 1'b1;
                state_n = RD_STREAM;
            end
            RD_STREAM: begin
                if (fire) begin
                    if (rd_addr == LAST_ADDR) begin
                        valid_n = 1'b0;
                        done_n  = 1'b1;
                        rd_free = 1'b1;
                        state_n = RD_IDLE;
                    end else begin
                        rd_addr_n = rd_addr + 1'b1;
                        rd_idx    = rd_addr + 1'b1;
                        pix_ld    = 1'b1;
                    end
                end
            end
            default: state_n = RD_IDLE;
        endcase
    end

    // Set (writer) and clear (reader) always hit different bits: the writer
    // only completes a bank that was empty, the reader only frees a full one.
    always_comb begin
        bank_full_n = bank_full;
        if (wr_last)
            bank_full_n[wr_bank] = 1'b1;
        if (rd_free)
            bank_full_n[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= RD_IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank    <= 1'b0;
            wr_addr    <= '0;
            rd_bank    <= 1'b0;
            rd_addr    <= '0;
            out_valid  <= 1'b0;
            out_pixel  <= '0;
            frame_done <= 1'b0;
            bank_full  <= '0;
            overflow   <= 1'b0;
        end else begin
            if (wr_en) begin
                if (wr_last) begin
                    wr_addr <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
            if (in_valid && bank_full[wr_bank])
                overflow <= 1'b1;
            if (pix_ld)
                out_pixel <= rd_bank ? mem1[rd_idx] : mem0[rd_idx];
            if (rd_free)
                rd_bank <= ~rd_bank;
            rd_addr    <= rd_addr_n;
            out_valid  <= valid_n;
            frame_done <= done_n;
            bank_full  <= bank_full_n;
        end
    end
endmodule

// File: tb/tb_pool_fmap_pingpong.sv
// Bench for pool_fmap_pingpong: map-level model (complete-map count, expected
// pixel queue) checked every cycle, plus directed literal expectations.
module tb_pool_fmap_pingpong;
    localparam int DEPTH = 196;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic signed [7:0] in_pixel = '0;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_pixel;
    logic              out_last;
    logic              frame_done;
    logic [1:0]        bank_full;
    logic              overflow;

    int errors = 0;
    int checks = 0;

    pool_fmap_pingpong #(.MAP_DIM(14), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pixel(in_pixel),
        .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
        .out_last(out_last), .frame_done(frame_done), .bank_full(bank_full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // out_ready driver: fixed level or the 1,0,0,1 stall pattern
    logic ready_lvl = 1'b0;
    logic bp_mode   = 1'b0;
    initial begin
        int k;
        k = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bp_mode)
                out_ready = (k % 4 == 0) || (k % 4 == 3);
            else
                out_ready = ready_lvl;
            k++;
        end
    end

    // Model: number of complete unread maps, the map being assembled, and the
    // queue of pixels the consumer must still see.
    int                cnt = 0;
    logic signed [7:0] partial[$];
    logic signed [7:0] expq[$];
    logic signed [7:0] rx[$];
    bit                ovf = 0;
    bit                done_pend = 0;
    int                bidx = 0;
    int                done_cnt = 0;
    bit                prev_rst = 0;
    bit                prev_stall = 0;
    logic signed [7:0] prev_pix;

    always @(negedge clk) begin
        bit fire, freed;
        if (prev_rst) begin
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_out_last", int'(out_last), 0);
            check("rst_frame_done", int'(frame_done), 0);
            check("rst_bank_full", int'(bank_full), 0);
            check("rst_overflow", int'(overflow), 0);
            check("rst_out_pixel", int'(out_pixel), 0);
        end
        if (rst) begin
            cnt = 0; partial.delete(); expq.delete();
            ovf = 0; done_pend = 0; bidx = 0; prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", int'(out_valid), 1);
                check("stall_hold_pixel", int'(out_pixel), int'(prev_pix));
            end
            check("frame_done", int'(frame_done), int'(done_pend));
            if (frame_done) done_cnt++;
            check("overflow", int'(overflow), int'(ovf));
            check("bank_full_count", $countones(bank_full), cnt);
            if (!out_valid) check("last_without_valid", int'(out_last), 0);
            fire = out_valid && out_ready;
            freed = 0;
            done_pend = 0;
            if (fire) begin
                if (expq.size() == 0) begin
                    check("spurious_beat", 1, 0);
                end else begin
                    check("beat_pixel", int'(out_pixel), int'(expq.pop_front()));
                    check("beat_last", int'(out_last), int'(bidx == DEPTH - 1));
                end
                rx.push_back(out_pixel);
                if (bidx == DEPTH - 1) begin
                    bidx = 0; freed = 1; done_pend = 1;
                end else begin
                    bidx++;
                end
            end
            if (in_valid) begin
                if (cnt == 2) begin
                    ovf = 1;
                end else begin
                    partial.push_back(in_pixel);
                    if (partial.size() == DEPTH) begin
                        foreach (partial[i]) expq.push_back(partial[i]);
                        partial.delete();
                        cnt++;
                    end
                end
            end
            if (freed) cnt--;
            prev_stall = out_valid && !out_ready;
            prev_pix = out_pixel;
        end
        prev_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic signed [7:0] pix(input int kind, input int i);
        logic [31:0] v;
        case (kind)
            0: v = i;
            1: v = i * 7 + 3;
            2: v = -5;
            3: v = 77;
            default: v = (i % 2) ? 127 : -128;
        endcase
        return v[7:0];
    endfunction

    task automatic write_map(input int kind);
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_pixel = pix(kind, i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (expq.size() != 0 && t < 3000) begin
            tick();
            t++;
        end
        if (t >= 3000) check("drain_timeout", 1, 0);
        repeat (4) tick();
    endtask

    initial begin
        int base, dn0, t;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // single map with out_ready high, latency and literal pins
        ready_lvl = 1'b1;
        tick();
        base = rx.size();
        dn0 = done_cnt;
        write_map(0);
        @(negedge clk); check("lat_edge0", int'(out_valid), 0);
        @(negedge clk); check("lat_edge1", int'(out_valid), 0);
        @(negedge clk); check("lat_edge2", int'(out_valid), 1);
        drain();
        check("t1_count", rx.size() - base, DEPTH);
        check("t1_pix0", int'(rx[base]), 0);
        check("t1_pix127", int'(rx[base + 127]), 127);
        check("t1_pix128", int'(rx[base + 128]), -128);
        check("t1_pix195", int'(rx[base + 195]), -61);
        check("t1_done", done_cnt - dn0, 1);
        check("t1_bank_full", int'(bank_full), 0);

        // backpressure while writing and reading
        bp_mode = 1'b1;
        base = rx.size();
        write_map(1);
        drain();
        bp_mode = 1'b0;
        check("bp_count", rx.size() - base, DEPTH);
        check("bp_pix5", int'(rx[base + 5]), 38);

        // ping-pong with reader stalled, then one overflowing pixel
        ready_lvl = 1'b0;
        repeat (2) tick();
        write_map(2);
        write_map(3);
        repeat (8) tick();
        check("pp_bank_full", int'(bank_full), 3);
        check("pp_overflow", int'(overflow), 0);
        in_valid = 1'b1;
        in_pixel = 8'sd99;
        tick();
        in_valid = 1'b0;
        tick();
        check("ovf_set", int'(overflow), 1);
        base = rx.size();
        dn0 = done_cnt;
        ready_lvl = 1'b1;
        drain();
        check("pp_count", rx.size() - base, 2 * DEPTH);
        check("pp_a0", int'(rx[base]), -5);
        check("pp_a195", int'(rx[base + 195]), -5);
        check("pp_b0", int'(rx[base + 196]), 77);
        check("pp_b195", int'(rx[base + 391]), 77);
        check("pp_done", done_cnt - dn0, 2);
        check("ovf_sticky", int'(overflow), 1);

        // reset on beat 50 of a map
        base = rx.size();
        write_map(0);
        t = 0;
        while (rx.size() < base + 50 && t < 1000) begin
            tick();
            t++;
        end
        if (t >= 1000) check("rst_wait_timeout", 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_bank_full", int'(bank_full), 0);
        tick();

        // fresh map of signed extremes
        base = rx.size();
        write_map(4);
        drain();
        check("ext_count", rx.size() - base, DEPTH);
        check("ext_pix0", int'(rx[base]), -128);
        check("ext_pix1", int'(rx[base + 1]), 127);
        check("ext_pix195", int'(rx[base + 195]), 127);
        check("ext_overflow", int'(overflow), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
